// File: rtl/ex_forward_ctrl_if.sv
// ex_forward_ctrl_if: ID-side hazard bundle. master drives the ID fields.
// slave returns ForwardA/B, Stall and, with FWD_STATS_EN, StallCount.
interface ex_forward_ctrl_if #(
  parameter int REG_AW = 3
);
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              ID_UsesRt;
  logic [REG_AW-1:0] ID_DestReg;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_Valid;
  logic              Flush;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              Stall;
`ifdef FWD_STATS_EN
  logic [15:0]       StallCount;
`endif

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt,
    output ID_DestReg, ID_RegWrite,
    output ID_MemRead, ID_Valid, Flush,
    input  ForwardA, ForwardB, Stall
`ifdef FWD_STATS_EN
    , input StallCount
`endif
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt,
    input  ID_DestReg, ID_RegWrite,
    input  ID_MemRead, ID_Valid, Flush,
    output ForwardA, ForwardB, Stall
`ifdef FWD_STATS_EN
    , output StallCount
`endif
  );
endinterface

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX operand forward selects and load-use Stall request.
// Ports: Clk, Rst_n (async low), bus (slave). FWD_STATS_EN adds StallCount.
module ex_forward_ctrl #(
  parameter int REG_AW = 3
) (
  input logic              Clk,
  input logic              Rst_n,
  ex_forward_ctrl_if.slave bus
);

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              wr;
    logic              ld;
  } exSh_t;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              wr;
  } memSh_t;

  exSh_t      exSh;
  memSh_t     memSh;
  exSh_t      exNext;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic [1:0] fwdANext;
  logic [1:0] fwdBNext;
  logic       loadUse;
  logic       bubble;

  function automatic logic hit(
    input logic              wr,
    input logic [REG_AW-1:0] dest,
    input logic [REG_AW-1:0] r
  );
    return wr && (dest != '0) && (dest == r);
  endfunction

  // Newer producer (EX shadow) wins over MEM shadow.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] r
  );
    if (hit(exSh.wr, exSh.dest, r))
      return 2'b10;
    else if (hit(memSh.wr, memSh.dest, r))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    loadUse = 1'b0;
    if (bus.ID_Valid && !bus.Flush &&
        exSh.ld && exSh.wr &&
        exSh.dest != '0)
      loadUse =
        (exSh.dest == bus.ID_Rs) ||
        (bus.ID_UsesRt &&
         exSh.dest == bus.ID_Rt);
  end

  always_comb begin
    bubble   = loadUse || bus.Flush;
    exNext   = '0;
    fwdANext = 2'b00;
    fwdBNext = 2'b00;
    if (!bubble) begin
      exNext.dest = bus.ID_DestReg;
      exNext.wr   = bus.ID_RegWrite
                    & bus.ID_Valid;
      exNext.ld   = bus.ID_MemRead
                    & bus.ID_Valid;
      fwdANext    = fwdSel(bus.ID_Rs);
      if (bus.ID_UsesRt)
        fwdBNext  = fwdSel(bus.ID_Rt);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      exSh  <= '0;
      memSh <= '0;
      fwdA  <= 2'b00;
      fwdB  <= 2'b00;
    end else begin
      exSh       <= exNext;
      memSh.dest <= exSh.dest;
      memSh.wr   <= exSh.wr;
      fwdA       <= fwdANext;
      fwdB       <= fwdBNext;
    end
  end

  assign bus.ForwardA = fwdA;
  assign bus.ForwardB = fwdB;
  assign bus.Stall    = loadUse;

`ifdef FWD_STATS_EN
  logic [15:0] stallCnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      stallCnt <= '0;
    else if (loadUse && stallCnt != 16'hFFFF)
      stallCnt <= stallCnt + 16'd1;
  end

  assign bus.StallCount = stallCnt;
`endif

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl: directed + random bench for ex_forward_ctrl.
// Reference keeps a queue of the last two captured instructions.
module tb_ex_forward_ctrl;
  localparam int AW = 3;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;

  ex_forward_ctrl_if #(.REG_AW(AW)) bus();

  ex_forward_ctrl #(.REG_AW(AW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] dest;
    logic          wr;
    logic          ld;
  } ent_t;

  ent_t       hist[$];
  logic [1:0] mFA;
  logic [1:0] mFB;
  int         mCnt;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit hitM(input ent_t e,
                              input logic [AW-1:0] r);
    return e.wr && e.dest != 0 && e.dest == r;
  endfunction

  function automatic logic [1:0] fsel(
    input logic [AW-1:0] r);
    if (hitM(hist[0], r)) return 2'b10;
    if (hitM(hist[1], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mStall();
    ent_t e;
    e = hist[0];
    return bus.ID_Valid && !bus.Flush && e.ld && e.wr
      && e.dest != 0
      && (e.dest == bus.ID_Rs
          || (bus.ID_UsesRt && e.dest == bus.ID_Rt));
  endfunction

  task automatic mReset();
    ent_t b;
    b = '{dest: '0, wr: 1'b0, ld: 1'b0};
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    mFA  = 2'b00;
    mFB  = 2'b00;
    mCnt = 0;
  endtask

  task automatic drive(input int rs, input int rt,
                       input bit ur, input int dst,
                       input bit rw, input bit mr,
                       input bit v, input bit fl);
    bus.ID_Rs       = AW'(rs);
    bus.ID_Rt       = AW'(rt);
    bus.ID_UsesRt   = ur;
    bus.ID_DestReg  = AW'(dst);
    bus.ID_RegWrite = rw;
    bus.ID_MemRead  = mr;
    bus.ID_Valid    = v;
    bus.Flush       = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Compare at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    bit         st;
    bit         bub;
    ent_t       e;
    logic [1:0] nA;
    logic [1:0] nB;
    @(negedge Clk);
    chk("ForwardA", int'(bus.ForwardA), int'(mFA));
    chk("ForwardB", int'(bus.ForwardB), int'(mFB));
    chk("Stall", int'(bus.Stall), int'(mStall()));
`ifdef FWD_STATS_EN
    chk("StallCount", int'(bus.StallCount), mCnt);
`endif
    @(posedge Clk);
    if (Rst_n) begin
      st  = mStall();
      bub = st || bus.Flush;
      nA  = bub ? 2'b00 : fsel(bus.ID_Rs);
      nB  = (bub || !bus.ID_UsesRt) ? 2'b00
                                    : fsel(bus.ID_Rt);
      if (bub)
        e = '{dest: '0, wr: 1'b0, ld: 1'b0};
      else
        e = '{dest: bus.ID_DestReg,
              wr: bus.ID_RegWrite && bus.ID_Valid,
              ld: bus.ID_MemRead && bus.ID_Valid};
      hist.push_front(e);
      void'(hist.pop_back());
      mFA = nA;
      mFB = nB;
      if (st && mCnt < 65535) mCnt++;
    end
    #1;
  endtask

  // Entered at posedge+1; asserts reset mid-cycle and checks async clear.
  task automatic resetSeq();
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_Stall", int'(bus.Stall), 0);
    chk("rst_FwdA", int'(bus.ForwardA), 0);
    chk("rst_FwdB", int'(bus.ForwardB), 0);
`ifdef FWD_STATS_EN
    chk("rst_Count", int'(bus.StallCount), 0);
`endif
    mReset();
    tick();
    Rst_n = 1'b1;
  endtask

  initial begin
    mReset();
    drive(5, 6, 1, 7, 1, 1, 1, 0);
    #2 Rst_n = 1'b0;
    #1;
    chk("init_Stall", int'(bus.Stall), 0);
    chk("init_FwdA", int'(bus.ForwardA), 0);
    chk("init_FwdB", int'(bus.ForwardB), 0);
`ifdef FWD_STATS_EN
    chk("init_Count", int'(bus.StallCount), 0);
`endif
    tick();
    tick();
    Rst_n = 1'b1;
    nop(); tick(); tick();

    // EX-EX forward
    drive(0, 0, 0, 2, 1, 0, 1, 0); tick();
    drive(2, 3, 1, 1, 1, 0, 1, 0); tick();
    chk("exex_A", int'(bus.ForwardA), 2);
    chk("exex_B", int'(bus.ForwardB), 0);

    // async reset mid-run clears live 10 select
    nop(); resetSeq();
    nop(); tick(); tick();

    // two producers of r4: newest wins
    drive(0, 0, 0, 4, 1, 0, 1, 0); tick();
    drive(0, 0, 0, 4, 1, 0, 1, 0); tick();
    drive(4, 4, 1, 1, 1, 0, 1, 0); tick();
    chk("prio_A", int'(bus.ForwardA), 2);
    chk("prio_B", int'(bus.ForwardB), 2);
    nop(); tick(); tick();

    // unrelated instruction in between -> MEM forward
    drive(0, 0, 0, 4, 1, 0, 1, 0); tick();
    drive(0, 0, 0, 7, 1, 0, 1, 0); tick();
    drive(4, 4, 1, 1, 1, 0, 1, 0); tick();
    chk("mem_A", int'(bus.ForwardA), 1);
    chk("mem_B", int'(bus.ForwardB), 1);
    nop(); tick(); tick();

    // load-use after fresh reset
    resetSeq();
    nop(); tick();
    drive(0, 0, 0, 5, 1, 1, 1, 0); tick();
    drive(5, 0, 0, 3, 1, 0, 1, 0);
    #1 chk("lu_Stall1", int'(bus.Stall), 1);
    tick();
    chk("lu_bubA", int'(bus.ForwardA), 0);
    #1 chk("lu_Stall2", int'(bus.Stall), 0);
    tick();
    chk("lu_FwdA", int'(bus.ForwardA), 1);
`ifdef FWD_STATS_EN
    chk("lu_Count", int'(bus.StallCount), 1);
`endif
    nop(); tick(); tick();

    // register 0 never hits or stalls
    drive(0, 0, 0, 0, 1, 1, 1, 0); tick();
    drive(0, 0, 1, 1, 1, 0, 1, 0);
    #1 chk("r0_Stall", int'(bus.Stall), 0);
    tick();
    chk("r0_FwdA", int'(bus.ForwardA), 0);
    nop(); tick(); tick();

    // UsesRt=0 masks the Rt compare
    drive(0, 0, 0, 6, 1, 1, 1, 0); tick();
    drive(1, 6, 0, 2, 1, 0, 1, 0);
    #1 chk("ur_Stall", int'(bus.Stall), 0);
    tick();
    chk("ur_FwdB", int'(bus.ForwardB), 0);
    nop(); tick(); tick();

    // flush overrides stall
    drive(0, 0, 0, 1, 1, 1, 1, 0); tick();
    drive(1, 0, 0, 3, 1, 0, 1, 1);
    #1 chk("fl_Stall", int'(bus.Stall), 0);
    tick();
    chk("fl_FwdA", int'(bus.ForwardA), 0);
    chk("fl_FwdB", int'(bus.ForwardB), 0);
    nop(); tick(); tick();

    // reset while a stall is pending
    drive(0, 0, 0, 3, 1, 1, 1, 0); tick();
    drive(3, 0, 0, 2, 1, 0, 1, 0);
    #1 chk("ms_Stall", int'(bus.Stall), 1);
    resetSeq();
    nop(); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 0) ? 3 : 7;
      drive($urandom_range(0, lim),
            $urandom_range(0, lim),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, lim),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 9,
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0)
        resetSeq();
      else
        tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
